// File: rtl/vga_crtc_timing.sv
// Raster timing generator for the text-mode video path.
// A 2-bit sub-pixel phase divides the system clock by four; on the last phase
// the horizontal and vertical counters advance. Every output is a register
// loaded from the next-state counters, so sync/enable levels line up with the
// counter values they describe in the same cycle. CRTC start-address and
// cursor registers are shadowed and only reloaded on the frame wrap, so
// CPU writes never tear a visible frame.
module vga_crtc_timing #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 400,
    parameter int   V_FRONT   = 12,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 35,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] start_addr_i,
    input  logic [5:0]  cur_start_i,
    input  logic [5:0]  cur_end_i,
    input  logic [4:0]  vcursor_i,
    input  logic [6:0]  hcursor_i,
    output logic [1:0]  h_subpixel,
    output logic [9:0]  h_count,
    output logic [9:0]  v_count,
    output logic        horiz_sync,
    output logic        vert_sync,
    output logic        video_on_h,
    output logic        video_on_v,
    output logic        frame_start,
    output logic [15:0] start_addr,
    output logic [5:0]  cur_start,
    output logic [5:0]  cur_end,
    output logic [4:0]  vcursor,
    output logic [6:0]  hcursor
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Sync level for a counter value: active polarity inside [beg, fin).
    function automatic logic sync_level(input logic [9:0] cnt,
                                        input logic [9:0] beg,
                                        input logic [9:0] fin,
                                        input logic       pol);
        if ((cnt >= beg) && (cnt < fin)) begin
            return pol;
        end else begin
            return ~pol;
        end
    endfunction

    logic [1:0]  r_subpixel;
    logic [9:0]  r_h_count;
    logic [9:0]  r_v_count;
    logic        r_horiz_sync;
    logic        r_vert_sync;
    logic        r_video_on_h;
    logic        r_video_on_v;
    logic        r_frame_start;
    logic [15:0] r_start_addr;
    logic [5:0]  r_cur_start;
    logic [5:0]  r_cur_end;
    logic [4:0]  r_vcursor;
    logic [6:0]  r_hcursor;

    logic        w_tick;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_wrap;
    logic [9:0]  w_h_next;
    logic [9:0]  w_v_next;

    // Next-state counters: advance on the pixel tick, wrap at the totals.
    always_comb begin
        w_tick       = enable & (r_subpixel == 2'd3);
        w_h_last     = (r_h_count == H_LAST);
        w_v_last     = (r_v_count == V_LAST);
        w_frame_wrap = w_tick & w_h_last & w_v_last;
        w_h_next     = r_h_count;
        w_v_next     = r_v_count;
        if (w_tick) begin
            if (w_h_last) begin
                w_h_next = 10'd0;
            end else begin
                w_h_next = r_h_count + 10'd1;
            end
        end else begin
            w_h_next = r_h_count;
        end
        if (w_tick && w_h_last) begin
            if (w_v_last) begin
                w_v_next = 10'd0;
            end else begin
                w_v_next = r_v_count + 10'd1;
            end
        end else begin
            w_v_next = r_v_count;
        end
    end

    // Timing state, decoded levels, frame strobe and frame-synchronous shadows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_subpixel    <= 2'd0;
            r_h_count     <= 10'd0;
            r_v_count     <= 10'd0;
            r_horiz_sync  <= ~HSYNC_POL;
            r_vert_sync   <= ~VSYNC_POL;
            r_video_on_h  <= 1'b1;
            r_video_on_v  <= 1'b1;
            r_frame_start <= 1'b0;
            r_start_addr  <= 16'h0000;
            r_cur_start   <= 6'd0;
            r_cur_end     <= 6'd0;
            r_vcursor     <= 5'd0;
            r_hcursor     <= 7'd0;
        end else if (enable) begin
            r_subpixel    <= r_subpixel + 2'd1;
            r_h_count     <= w_h_next;
            r_v_count     <= w_v_next;
            r_horiz_sync  <= sync_level(w_h_next, H_SYNC_BEG, H_SYNC_END, HSYNC_POL);
            r_vert_sync   <= sync_level(w_v_next, V_SYNC_BEG, V_SYNC_END, VSYNC_POL);
            r_video_on_h  <= (w_h_next < H_VIS_END);
            r_video_on_v  <= (w_v_next < V_VIS_END);
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_start_addr <= start_addr_i;
                r_cur_start  <= cur_start_i;
                r_cur_end    <= cur_end_i;
                r_vcursor    <= vcursor_i;
                r_hcursor    <= hcursor_i;
            end else begin
                r_start_addr <= r_start_addr;
                r_cur_start  <= r_cur_start;
                r_cur_end    <= r_cur_end;
                r_vcursor    <= r_vcursor;
                r_hcursor    <= r_hcursor;
            end
        end else begin
            // Frozen: everything holds, only the strobe is forced low.
            r_frame_start <= 1'b0;
        end
    end

    assign h_subpixel  = r_subpixel;
    assign h_count     = r_h_count;
    assign v_count     = r_v_count;
    assign horiz_sync  = r_horiz_sync;
    assign vert_sync   = r_vert_sync;
    assign video_on_h  = r_video_on_h;
    assign video_on_v  = r_video_on_v;
    assign frame_start = r_frame_start;
    assign start_addr  = r_start_addr;
    assign cur_start   = r_cur_start;
    assign cur_end     = r_cur_end;
    assign vcursor     = r_vcursor;
    assign hcursor     = r_hcursor;

endmodule

// File: doc/vga_crtc_timing.md
# vga_crtc_timing

Raster timing generator for the text-mode video path. Produces the pixel-rate subpixel phase, horizontal and vertical counters, sync and display-enable levels, and a frame-start strobe, all at the system clock with a 1-in-4 pixel enable. Feeds the text-mode renderer directly. Also holds frame-synchronous shadow copies of the CRTC start-address and cursor registers, so CPU writes never tear a visible frame.

## Interface

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 400, visible lines per frame
- V_FRONT, 12, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 35, vertical back porch (lines)
- HSYNC_POL, 0, active level of horiz_sync
- VSYNC_POL, 1, active level of vert_sync

Ports:
- clk  in  1  system clock (4x pixel rate)
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  timing run enable; low freezes all state
- start_addr_i  in  16  CRTC start address (CPU side)
- cur_start_i  in  6  cursor start scanline
- cur_end_i  in  6  cursor end scanline
- vcursor_i  in  5  cursor row
- hcursor_i  in  7  cursor column
- h_subpixel  out  2  pixel phase; 3 marks the pixel tick
- h_count  out  10  horizontal pixel counter
- v_count  out  10  vertical line counter
- horiz_sync  out  1  horizontal sync level
- vert_sync  out  1  vertical sync level
- video_on_h  out  1  horizontal display enable
- video_on_v  out  1  vertical display enable
- frame_start  out  1  one-clk strobe at (0,0), phase 0
- start_addr  out  16  shadowed start address
- cur_start, cur_end, vcursor, hcursor  out  6/6/5/7  shadowed cursor registers

## Operation

- Definitions:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (449).
  - tick = enable & (h_subpixel==3).
- h_subpixel: increments modulo 4 on every clk with enable high.
- h_count: increments on tick; at H_TOTAL-1 wraps to 0.
- v_count: increments on a tick where h_count==H_TOTAL-1; at V_TOTAL-1 wraps to 0.
- video_on_h = (h_count < H_VISIBLE).
- video_on_v = (v_count < V_VISIBLE).
- horiz_sync = HSYNC_POL while h_count is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), otherwise !HSYNC_POL.
- vert_sync: same rule on v_count with the V_* parameters and VSYNC_POL.
- Output registration: all of the above are registered and computed from the next-state counters, so every level is aligned with the h_count/v_count value it describes in the same cycle. No output is decoded combinationally from counters.
- Shadow registers:
  - Load from their *_i inputs on the tick that wraps both counters to (0,0).
  - Hold otherwise; stable for the whole frame.
  - CPU-side changes mid-frame are invisible until the next frame.
- frame_start: high for exactly the one clk in which h_count==0, v_count==0 and h_subpixel==0 after a wrap. Not asserted out of reset.
- enable low: all counters, levels, shadows and frame_start hold their values (frame_start forced 0). Resuming continues from the frozen phase.
- Reset, asynchronous on rst_n low:
  - h_subpixel=0, h_count=0, v_count=0.
  - video_on_h=1, video_on_v=1.
  - horiz_sync=!HSYNC_POL, vert_sync=!VSYNC_POL.
  - frame_start=0.
  - All shadow outputs 0.
- Reset mid-frame returns to this state immediately; counting restarts on the first enabled clk after rst_n rises.

## Timing

- Pixel period 4 clk.
- Line period H_TOTAL*4 = 3200 clk.
- Frame period H_TOTAL*V_TOTAL*4 = 1,436,800 clk.
- Counter and level outputs change only on the clk following a tick. h_subpixel then reads 0.
- Zero latency between a counter value and its decoded sync/enable levels (same cycle).
- Shadow outputs change in the same cycle as frame_start.
- The downstream renderer's internal 10-stage delay is outside this block; no compensation is applied here.

## Test plan

- Reset then enable=1: h_subpixel cycles 0,1,2,3. h_count reaches 1 at clk 4 and 799 at clk 3196, then wraps to 0 at clk 3200. v_count reaches 1 at clk 3200.
- Horizontal levels over one line:
  - horiz_sync=0 exactly for h_count 656..751 (384 clk).
  - video_on_h=1 for h_count 0..639, 0 for 640..799.
- Vertical levels over one frame:
  - vert_sync=1 for v_count 412..413.
  - video_on_v=0 for v_count 400..448.
  - frame_start pulses once per 1,436,800 clk.
- Shadow update: write start_addr_i=16'h0050 at v_count=100. start_addr stays at the old value until frame_start, then equals 16'h0050. Same check for hcursor_i=7'd79 and vcursor_i=5'd24.
- Enable hold: drop enable for 37 clk at h_count=500, h_subpixel=2. All outputs hold, frame_start=0. Counting resumes from phase 2 and the line period stretches to 3237 clk.
- Asynchronous reset at v_count=300, h_count=700: outputs immediately equal reset values, without waiting for a clk edge. After release, the first frame_start occurs 1,436,800 enabled clk later.
